// File: rtl/debug_cmd_if.sv
// debug_cmd_if: host command handshake between the debug command decoder and the run controller.
// Ports: CMD_VALID/CMD_OP/CMD_COUNT from host, CMD_READY back to host.
interface debug_cmd_if #(
  parameter int CNT_W = 8
);
  logic             CMD_VALID;
  logic [1:0]       CMD_OP;
  logic [CNT_W-1:0] CMD_COUNT;
  logic             CMD_READY;
  modport master (output CMD_VALID, CMD_OP, CMD_COUNT, input CMD_READY);
  modport slave  (input CMD_VALID, CMD_OP, CMD_COUNT, output CMD_READY);
endinterface

// File: rtl/debug_run_controller.sv
// debug_run_controller: sequences HALT/RUN/STEP(n) and a PC breakpoint onto the phase decoder debug interface.
// Ports: CLK, RESET (async, active-high); cmd (host command handshake);
//   BP_WE/BP_ADDR_IN/BP_EN_IN breakpoint load; PC/FETCH observed program flow;
//   STOPPED/DEBUG_ACTIVE/DEBUG_STEP_ACK decoder status; DEBUG_STOPX/DEBUG_STEP_REQ decoder control;
//   HALTED/DONE/BREAK_HIT/STEP_ERR/CMD_ERR/STEPS_LEFT status to host. All outputs registered.
module debug_run_controller #(
  parameter int CNT_W        = 8,
  parameter int ADDR_W       = 16,
  parameter int ACK_TIMEOUT  = 63,
  parameter int RESET_HALTED = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  debug_cmd_if.slave        cmd,
  input  logic              BP_WE,
  input  logic [ADDR_W-1:0] BP_ADDR_IN,
  input  logic              BP_EN_IN,
  input  logic [ADDR_W-1:0] PC,
  input  logic              FETCH,
  input  logic              STOPPED,
  input  logic              DEBUG_ACTIVE,
  input  logic              DEBUG_STEP_ACK,
  output logic              DEBUG_STOPX,
  output logic              DEBUG_STEP_REQ,
  output logic              HALTED,
  output logic              DONE,
  output logic              BREAK_HIT,
  output logic              STEP_ERR,
  output logic              CMD_ERR,
  output logic [CNT_W-1:0]  STEPS_LEFT
);
  typedef enum logic [2:0] {S_RUN, S_STOPPING, S_HALTED, S_STEP_REQ, S_STEP_REL} state_t;
  localparam state_t S_RST = (RESET_HALTED != 0) ? S_STOPPING : S_RUN;
  localparam int TW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [1:0] OP_HALT = 2'b01, OP_RUN = 2'b10, OP_STEP = 2'b11;
  state_t            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d, tmr_inc;
  logic [CNT_W-1:0]  steps_q, steps_d;
  logic [ADDR_W-1:0] bp_addr_q, bp_addr_d;
  logic              bp_en_q, bp_en_d;
  logic              stopx_q, stopx_d, req_q, req_d, halted_q, halted_d, done_q, done_d;
  logic              brk_q, brk_d, serr_q, serr_d, cerr_q, cerr_d, ready_q, ready_d;
  logic              acc, parked, bp_hit, halt_acc, run_acc, step_acc;
  assign acc      = cmd.CMD_VALID & ready_q;
  assign halt_acc = acc & (cmd.CMD_OP == OP_HALT);
  assign run_acc  = acc & (cmd.CMD_OP == OP_RUN);
  assign step_acc = acc & (cmd.CMD_OP == OP_STEP);
  assign parked   = STOPPED & DEBUG_ACTIVE & ~DEBUG_STEP_ACK;
  assign bp_hit   = FETCH & bp_en_q & (PC == bp_addr_q);
  assign tmr_inc  = tmr_q + 1'b1;
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    steps_d   = steps_q;
    brk_d     = brk_q;
    serr_d    = serr_q;
    cerr_d    = 1'b0;
    bp_addr_d = BP_WE ? BP_ADDR_IN : bp_addr_q;
    bp_en_d   = BP_WE ? BP_EN_IN : bp_en_q;
    case (state_q)
      S_RUN: begin
        // a HALT racing a breakpoint match still reports the breakpoint
        brk_d   = brk_q | bp_hit;
        state_d = (bp_hit | halt_acc) ? S_STOPPING : S_RUN;
        cerr_d  = step_acc;
      end
      S_STOPPING: state_d = parked ? S_HALTED : S_STOPPING;
      S_HALTED: begin
        if (run_acc | step_acc) begin
          brk_d  = 1'b0;
          serr_d = 1'b0;
        end
        if (run_acc) state_d = S_RUN;
        if (step_acc) begin
          state_d = S_STEP_REQ;
          steps_d = (cmd.CMD_COUNT == '0) ? CNT_W'(1) : cmd.CMD_COUNT;
          tmr_d   = '0;
        end
      end
      S_STEP_REQ: begin
        // REQ is held for exactly ACK_TIMEOUT cycles when no ACK arrives
        if (DEBUG_STEP_ACK) state_d = S_STEP_REL;
        else if (tmr_inc == TW'(ACK_TIMEOUT)) begin
          state_d = S_STOPPING;
          serr_d  = 1'b1;
          steps_d = '0;
        end else tmr_d = tmr_inc;
      end
      S_STEP_REL: begin
        if (!DEBUG_STEP_ACK) begin
          steps_d = steps_q - 1'b1;
          state_d = (steps_d == '0) ? S_HALTED : S_STEP_REQ;
          tmr_d   = '0;
        end
      end
      default: state_d = S_STOPPING;
    endcase
    // outputs are registered from the next state so they move on the same edge as the FSM
    stopx_d  = state_d != S_RUN;
    req_d    = state_d == S_STEP_REQ;
    halted_d = state_d == S_HALTED;
    ready_d  = (state_d == S_RUN) | (state_d == S_HALTED);
    done_d   = halted_d & ((state_q != S_HALTED) | halt_acc);
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_RST;
      tmr_q     <= '0;
      steps_q   <= '0;
      bp_addr_q <= '0;
      bp_en_q   <= 1'b0;
      stopx_q   <= RESET_HALTED != 0;
      req_q     <= 1'b0;
      halted_q  <= 1'b0;
      done_q    <= 1'b0;
      brk_q     <= 1'b0;
      serr_q    <= 1'b0;
      cerr_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      steps_q   <= steps_d;
      bp_addr_q <= bp_addr_d;
      bp_en_q   <= bp_en_d;
      stopx_q   <= stopx_d;
      req_q     <= req_d;
      halted_q  <= halted_d;
      done_q    <= done_d;
      brk_q     <= brk_d;
      serr_q    <= serr_d;
      cerr_q    <= cerr_d;
      ready_q   <= ready_d;
    end
  end
  assign cmd.CMD_READY  = ready_q;
  assign DEBUG_STOPX    = stopx_q;
  assign DEBUG_STEP_REQ = req_q;
  assign HALTED         = halted_q;
  assign DONE           = done_q;
  assign BREAK_HIT      = brk_q;
  assign STEP_ERR       = serr_q;
  assign CMD_ERR        = cerr_q;
  assign STEPS_LEFT     = steps_q;
endmodule

// File: doc/debug_run_controller.md
# debug_run_controller

Sequences the instruction phase decoder's debug interface (DEBUG_STOPX, DEBUG_STEP_REQ / DEBUG_STEP_ACK) on behalf of a host debug port. It accepts HALT / RUN / STEP(n) commands and performs the REQ/ACK handshake for each single step. It also stops the core on a single hardware PC breakpoint. It sits between the debug UART/JTAG command decoder and the phase decoder, and also observes the program counter.

## Interface
- CNT_W, 8: width of step count.
- ADDR_W, 16: PC/breakpoint width.
- ACK_TIMEOUT, 63: cycles allowed from REQ rise to ACK rise before a step is aborted.
- RESET_HALTED, 1: 1 = come out of reset requesting stop; 0 = come out of reset running.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset, asynchronous, active-high.
- CMD_VALID  in  1  command strobe; accepted when CMD_VALID & CMD_READY.
- CMD_OP  in  2  00 NOP, 01 HALT, 10 RUN, 11 STEP.
- CMD_COUNT  in  CNT_W  step count for STEP; 0 treated as 1.
- CMD_READY  out  1  controller can accept a command.
- BP_WE  in  1  load BP_ADDR/BP_EN registers.
- BP_ADDR_IN  in  ADDR_W  breakpoint address.
- BP_EN_IN  in  1  breakpoint enable.
- PC  in  ADDR_W  current program counter.
- FETCH, STOPPED, DEBUG_ACTIVE, DEBUG_STEP_ACK  in  1 each  status from phase decoder.
- DEBUG_STOPX  out  1  stop request to phase decoder.
- DEBUG_STEP_REQ  out  1  step request to phase decoder.
- HALTED  out  1  core parked in debug-stopped.
- DONE  out  1  one-cycle pulse on every entry to S_HALTED.
- BREAK_HIT  out  1  sticky; breakpoint caused the stop.
- STEP_ERR  out  1  sticky; a step timed out.
- CMD_ERR  out  1  one-cycle pulse on illegal command.
- STEPS_LEFT  out  CNT_W  remaining steps.

## Operation
States: S_RUN, S_STOPPING, S_HALTED, S_STEP_REQ, S_STEP_REL.
- Parked condition: PARKED = STOPPED & DEBUG_ACTIVE & ~DEBUG_STEP_ACK.
- **S_RUN.** DEBUG_STOPX=0, CMD_READY=1.
  - HALT → S_STOPPING.
  - RUN/NOP → no change.
  - STEP → CMD_ERR pulse, no change.
  - Breakpoint: FETCH & BP_EN & PC==BP_ADDR → set BREAK_HIT, go to S_STOPPING. The matching instruction completes.
  - If a HALT is accepted in the same cycle as a breakpoint match, BREAK_HIT is still set.
- **S_STOPPING.** DEBUG_STOPX=1, CMD_READY=0. Go to S_HALTED when PARKED.
- **S_HALTED.** DEBUG_STOPX=1, HALTED=1, CMD_READY=1.
  - HALT → DONE pulse, stay.
  - RUN → clear BREAK_HIT and STEP_ERR, go to S_RUN.
  - STEP → clear BREAK_HIT and STEP_ERR, load STEPS_LEFT=max(CMD_COUNT,1), go to S_STEP_REQ.
- **S_STEP_REQ.** DEBUG_STEP_REQ=1, timeout counter running.
  - DEBUG_STEP_ACK=1 → S_STEP_REL.
  - Counter reaches ACK_TIMEOUT → set STEP_ERR, STEPS_LEFT=0, go to S_STOPPING.
- **S_STEP_REL.** DEBUG_STEP_REQ=0.
  - When DEBUG_STEP_ACK=0: decrement STEPS_LEFT.
  - If the result is 0, go to S_HALTED (DONE pulse). Otherwise go to S_STEP_REQ.
- Breakpoints are ignored in all states except S_RUN.
- BP registers are written on BP_WE in any state.
- DEBUG_STOPX=1 in every state except S_RUN.

## Timing
- All outputs are registered.
- Reset values:
  - RESET_HALTED=1: state S_STOPPING, DEBUG_STOPX=1.
  - RESET_HALTED=0: state S_RUN, DEBUG_STOPX=0.
  - In both cases, all other outputs and the BP registers reset to 0.
- Command accept → state change on the next edge. DEBUG_STOPX or DEBUG_STEP_REQ changes 1 cycle after accept.
- Breakpoint: DEBUG_STOPX rises 1 cycle after the FETCH cycle in which PC matches.
- ACK seen high → REQ low on the next edge.
- Minimum REQ-low time between steps: 1 cycle, plus however long ACK stays high.
- The timeout counter clears on entry to S_STEP_REQ. The error is raised on the edge where count == ACK_TIMEOUT.
- STEPS_LEFT decrements in the cycle ACK is seen low in S_STEP_REL.
- RESET mid-step: REQ drops immediately, and the controller enters its reset state.
- CMD_VALID while CMD_READY=0 is ignored: no CMD_ERR, not queued.

## Test plan
- **Reset halt.** Reset with RESET_HALTED=1, model decoder parks after 4 cycles → DEBUG_STOPX=1 from reset, HALTED=1 and DONE pulse once PARKED, CMD_READY=1.
- **Step 3.** From HALTED, STEP with CMD_COUNT=3; model ACKs 6 cycles after REQ → exactly 3 REQ pulses, STEPS_LEFT goes 3→2→1→0, then one DONE pulse and HALTED=1.
- **Breakpoint.** RUN, BP_ADDR=0x0040 enabled; PC reaches 0x0040 with FETCH=1 → DEBUG_STOPX=1 next cycle, BREAK_HIT=1, HALTED after park. A following RUN clears BREAK_HIT.
- **Timeout.** STEP with CMD_COUNT=1, model never ACKs → REQ held 63 cycles then drops, STEP_ERR=1, returns to HALTED, STEPS_LEFT=0.
- **Illegal/edge commands.**
  - STEP in S_RUN → CMD_ERR pulse, DEBUG_STOPX stays 0.
  - CMD_COUNT=0 → exactly one step.
  - HALT in HALTED → DONE pulse only.
- **Reset mid-step.** RESET asserted while DEBUG_STEP_REQ=1 → REQ=0 asynchronously, state returns to the reset state.
